// File: rtl/pe_boot_ctrl.sv
// Boot/configuration sequencer for a processing element: drains the PE reset,
// streams host WRITEs into instruction memory, then gates the PE run enable.
module pe_boot_ctrl #(
    parameter int unsigned IMEM_AW = 10,
    parameter int unsigned RST_DLY = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [31:0]        cmd_data,
    output logic               imem_wr_en,
    output logic [IMEM_AW-1:0] imem_wr_addr,
    output logic [31:0]        imem_wr_data,
    output logic               conf_en,
    output logic               start_en,
    output logic [1:0]         state_o,
    input  logic               err_clr,
    output logic               err_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CONF  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_BEGIN = 2'd1;
    localparam logic [1:0] OP_START = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    localparam logic [3:0] DLY_LOAD = 4'(RST_DLY - 1);

    logic [1:0]         state_q, state_d;
    logic [IMEM_AW-1:0] ptr_q, ptr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               err_q, err_d, err_set;
    logic               wr_en_q, wr_en_d;
    logic [IMEM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic               conf_q, start_q;
    logic               accept;

    assign cmd_ready = (state_q != ST_DRAIN);
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_set   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_BEGIN: begin
                            state_d = ST_DRAIN;
                            ptr_d   = cmd_data[IMEM_AW-1:0];
                            cnt_d   = DLY_LOAD;
                        end
                        OP_START: state_d = ST_RUN;
                        OP_WRITE: err_set = 1'b1;
                        default:  ;
                    endcase
                end
            end
            ST_DRAIN: begin
                // Leave one cycle after the counter reads zero: RST_DLY cycles total.
                if (cnt_q == 4'd0) begin
                    state_d = ST_CONF;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CONF: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = cmd_data;
                            ptr_d     = ptr_q + IMEM_AW'(1);
                            err_set   = (ptr_q == {IMEM_AW{1'b1}});
                        end
                        OP_BEGIN: ptr_d   = cmd_data[IMEM_AW-1:0];
                        OP_START: state_d = ST_RUN;
                        OP_STOP:  state_d = ST_IDLE;
                        default:  ;
                    endcase
                end
            end
            ST_RUN: begin
                if (accept) begin
                    case (cmd_op)
                        OP_STOP:  state_d = ST_IDLE;
                        OP_BEGIN: begin
                            state_d = ST_DRAIN;
                            ptr_d   = cmd_data[IMEM_AW-1:0];
                            cnt_d   = DLY_LOAD;
                        end
                        OP_WRITE: err_set = 1'b1;
                        default:  ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh error outranks a same-cycle clear.
        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 32'd0;
            conf_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            conf_q    <= (state_d == ST_DRAIN) || (state_d == ST_CONF);
            start_q   <= (state_d == ST_RUN);
        end
    end

    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign conf_en      = conf_q;
    assign start_en     = start_q;
    assign state_o      = state_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_pe_boot_ctrl.sv
// Directed table-driven bench for pe_boot_ctrl; outputs are sampled 1 time unit
// after each rising edge and compared as one packed record per vector.
module tb_pe_boot_ctrl;

    localparam int AW = 10;
    localparam logic [1:0] W = 2'd0, B = 2'd1, S = 2'd2, P = 2'd3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [31:0]   cmd_data = 32'd0;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [31:0]   imem_wr_data;
    logic          conf_en;
    logic          start_en;
    logic [1:0]    state_o;
    logic          err_clr = 1'b0;
    logic          err_o;

    pe_boot_ctrl #(.IMEM_AW(AW), .RST_DLY(4)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .conf_en      (conf_en),
        .start_en     (start_en),
        .state_o      (state_o),
        .err_clr      (err_clr),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    // {ready, wr_en, addr, data, conf, start, state, err}
    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [31:0] data;
        logic        clr;
        logic [48:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic logic [48:0] ex(input logic rdy, input logic wr, input logic [AW-1:0] a,
                                       input logic [31:0] d, input logic c, input logic s,
                                       input logic [1:0] st, input logic e);
        return {rdy, wr, a, d, c, s, st, e};
    endfunction

    function automatic logic [48:0] actual();
        return {cmd_ready, imem_wr_en, imem_wr_addr, imem_wr_data, conf_en, start_en,
                state_o, err_o};
    endfunction

    task automatic add(input logic v, input logic [1:0] op, input logic [31:0] d,
                       input logic clr, input logic [48:0] e);
        vec_t t;
        t.v = v; t.op = op; t.data = d; t.clr = clr; t.exp = e;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [48:0] e);
        logic [48:0] a;
        a = actual();
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, a, e);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] d,
                        input logic clr, input logic [48:0] e, input string name);
        @(negedge clk);
        cmd_valid = v; cmd_op = op; cmd_data = d; err_clr = clr;
        @(posedge clk);
        #1;
        check(name, e);
    endtask

    localparam logic [31:0] DA = 32'h1111_1111, DB = 32'h2222_2222, DC = 32'h3333_3333;
    localparam logic [31:0] DD = 32'hDDDD_0001, DE = 32'hEEEE_0002, DF = 32'hFFFF_0003;
    localparam logic [48:0] RST = {1'b1, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0};

    initial begin
        // Idle and BEGIN_CONF(0x010) with a 4-cycle drain; a WRITE offered in DRAIN is ignored.
        add(0, W, 32'h0,        0, ex(1, 0, 10'h000, 32'h0, 0, 0, 2'd0, 0));
        add(1, B, 32'h010,      0, ex(0, 0, 10'h000, 32'h0, 1, 0, 2'd1, 0));
        add(1, W, 32'hDEAD_BEEF, 0, ex(0, 0, 10'h000, 32'h0, 1, 0, 2'd1, 0));
        add(0, W, 32'h0,        0, ex(0, 0, 10'h000, 32'h0, 1, 0, 2'd1, 0));
        add(0, W, 32'h0,        0, ex(0, 0, 10'h000, 32'h0, 1, 0, 2'd1, 0));
        add(0, W, 32'h0,        0, ex(1, 0, 10'h000, 32'h0, 1, 0, 2'd2, 0));
        // Back-to-back writes, then an invalid cycle with junk op/data.
        add(1, W, DA,           0, ex(1, 1, 10'h010, DA, 1, 0, 2'd2, 0));
        add(1, W, DB,           0, ex(1, 1, 10'h011, DB, 1, 0, 2'd2, 0));
        add(1, W, DC,           0, ex(1, 1, 10'h012, DC, 1, 0, 2'd2, 0));
        add(0, W, 32'h5555_5555, 0, ex(1, 0, 10'h012, DC, 1, 0, 2'd2, 0));
        // START, START no-op, WRITE error in RUN, clear, STOP, STOP no-op.
        add(1, S, 32'h0,        0, ex(1, 0, 10'h012, DC, 0, 1, 2'd3, 0));
        add(1, S, 32'h0,        0, ex(1, 0, 10'h012, DC, 0, 1, 2'd3, 0));
        add(1, W, 32'h7777_7777, 0, ex(1, 0, 10'h012, DC, 0, 1, 2'd3, 1));
        add(0, W, 32'h0,        1, ex(1, 0, 10'h012, DC, 0, 1, 2'd3, 0));
        add(1, P, 32'h0,        0, ex(1, 0, 10'h012, DC, 0, 0, 2'd0, 0));
        add(1, P, 32'h0,        0, ex(1, 0, 10'h012, DC, 0, 0, 2'd0, 0));
        // WRITE in IDLE with err_clr: the new error wins.
        add(1, W, 32'h8888_8888, 1, ex(1, 0, 10'h012, DC, 0, 0, 2'd0, 1));
        add(0, W, 32'h0,        1, ex(1, 0, 10'h012, DC, 0, 0, 2'd0, 0));
        // IDLE -> RUN, then BEGIN_CONF(0x3FF) from RUN, drain, wrap writes.
        add(1, S, 32'h0,        0, ex(1, 0, 10'h012, DC, 0, 1, 2'd3, 0));
        add(1, B, 32'h3FF,      0, ex(0, 0, 10'h012, DC, 1, 0, 2'd1, 0));
        add(0, W, 32'h0,        0, ex(0, 0, 10'h012, DC, 1, 0, 2'd1, 0));
        add(0, W, 32'h0,        0, ex(0, 0, 10'h012, DC, 1, 0, 2'd1, 0));
        add(0, W, 32'h0,        0, ex(0, 0, 10'h012, DC, 1, 0, 2'd1, 0));
        add(0, W, 32'h0,        0, ex(1, 0, 10'h012, DC, 1, 0, 2'd2, 0));
        add(1, W, DD,           0, ex(1, 1, 10'h3FF, DD, 1, 0, 2'd2, 1));
        add(1, W, DE,           0, ex(1, 1, 10'h000, DE, 1, 0, 2'd2, 1));
        add(0, W, 32'h0,        1, ex(1, 0, 10'h000, DE, 1, 0, 2'd2, 0));
        // BEGIN_CONF inside CONF reloads the pointer without draining.
        add(1, B, 32'h005,      0, ex(1, 0, 10'h000, DE, 1, 0, 2'd2, 0));
        add(1, W, DF,           0, ex(1, 1, 10'h005, DF, 1, 0, 2'd2, 0));
        add(1, P, 32'h0,        0, ex(1, 0, 10'h005, DF, 0, 0, 2'd0, 0));

        #3;
        check("reset_state", RST);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].op, tbl[i].data, tbl[i].clr, tbl[i].exp,
                 $sformatf("vec%0d", i));
        end

        // Asynchronous reset while RUN with non-zero write registers.
        step(1, S, 32'h0, 0, ex(1, 0, 10'h005, DF, 0, 1, 2'd3, 0), "run_before_rst");
        #2;
        rstn = 1'b0;
        #1;
        check("rst_in_run", RST);
        @(negedge clk);
        rstn = 1'b1;
        step(1, S, 32'h0, 0, ex(1, 0, 10'h000, 32'h0, 0, 1, 2'd3, 0), "start_after_rst_run");

        // Asynchronous reset mid-DRAIN, with a pending error to be cleared by reset.
        step(1, W, 32'h9, 0, ex(1, 0, 10'h000, 32'h0, 0, 1, 2'd3, 1), "err_before_drain");
        step(1, B, 32'h020, 0, ex(0, 0, 10'h000, 32'h0, 1, 0, 2'd1, 1), "drain_before_rst");
        step(0, W, 32'h0, 0, ex(0, 0, 10'h000, 32'h0, 1, 0, 2'd1, 1), "drain_mid");
        #2;
        rstn = 1'b0;
        #1;
        check("rst_in_drain", RST);
        @(negedge clk);
        rstn = 1'b1;
        step(1, S, 32'h0, 0, ex(1, 0, 10'h000, 32'h0, 0, 1, 2'd3, 0), "start_after_rst_drain");
        step(0, W, 32'h0, 0, ex(1, 0, 10'h000, 32'h0, 0, 1, 2'd3, 0), "no_write_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
